// File: rtl/edma_ctrl_pkg.sv
// edma_ctrl_pkg: FSM state encoding shared by the eDMA channel sequencer and its status readback
package edma_ctrl_pkg;
  localparam int CW_DEF = 16;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_XFER  = 3'd2,
    S_STALL = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_e;
endpackage

// File: rtl/edma_ctrl.sv
// edma_ctrl: per-channel eDMA sequencer issuing beats, 2D loop updates and done/error interrupts
module edma_ctrl
  import edma_ctrl_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk_i,
  input  logic          nreset_i,
  input  logic          dma_en_i,
  input  logic          mastermode_i,
  input  logic [2*CW-1:0] count_i,
  input  logic          access_in_i,
  input  logic          wait_in_i,
  output logic          master_active_o,
  output logic          update_o,
  output logic          update2d_o,
  output logic          dma_busy_o,
  output logic [2:0]    dma_state_o,
  output logic          irq_done_o,
  output logic          irq_err_o
);
  state_e state_q, state_d;
  logic en_q, mode_q, mode_d, ma_q, busy_q, done_q, err_q;
  logic [CW-1:0] inner, outer;
  logic beat, inner_one, last;
  assign inner     = count_i[CW-1:0];
  assign outer     = count_i[2*CW-1:CW];
  assign inner_one = inner == CW'(1);
  assign beat      = (state_q == S_XFER) & ~wait_in_i & (mode_q | access_in_i);
  assign last      = beat & inner_one & (outer == CW'(1));
  assign update_o   = beat;
  assign update2d_o = beat & inner_one & (outer > CW'(1));
  // abort on dma_en low takes priority over every other exit from an active state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = (dma_en_i & ~en_q) ? S_START : S_IDLE;
      S_START: state_d = ~dma_en_i ? S_IDLE : (inner == '0 || outer == '0) ? S_ERROR : S_XFER;
      S_XFER:  state_d = ~dma_en_i ? S_IDLE : wait_in_i ? S_STALL : last ? S_DONE : S_XFER;
      S_STALL: state_d = ~dma_en_i ? S_IDLE : wait_in_i ? S_STALL : S_XFER;
      default: state_d = S_IDLE;
    endcase
  end
  assign mode_d = (state_q == S_START) ? mastermode_i : mode_q;
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      mode_q  <= 1'b0;
      ma_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= dma_en_i;
      mode_q  <= mode_d;
      ma_q    <= (state_d == S_XFER) & mode_d;
      busy_q  <= state_d != S_IDLE;
      done_q  <= state_d == S_DONE;
      err_q   <= state_d == S_ERROR;
    end
  end
  assign master_active_o = ma_q;
  assign dma_busy_o      = busy_q;
  assign dma_state_o     = state_q;
  assign irq_done_o      = done_q;
  assign irq_err_o       = err_q;
endmodule

// File: tb/tb_edma_ctrl.sv
// tb_edma_ctrl: randomized transfers against a rule-based cycle model with a register-file count emulation
module tb_edma_ctrl;
  localparam int CW = 16;
  logic clk_i = 1'b0;
  logic nreset_i, dma_en_i, mastermode_i, access_in_i, wait_in_i;
  logic [2*CW-1:0] count_i;
  logic master_active_o, update_o, update2d_o, dma_busy_o, irq_done_o, irq_err_o;
  logic [2:0] dma_state_o;
  logic [CW-1:0] inner, outer, reload;
  int n_tests = 0, n_fail = 0;
  logic [8:0] obs;
  always #5 clk_i = ~clk_i;
  assign count_i = {outer, inner};
  assign obs = {dma_state_o, dma_busy_o, master_active_o, update_o, update2d_o, irq_done_o, irq_err_o};
  edma_ctrl #(.CW(CW)) dut (
    .clk_i(clk_i), .nreset_i(nreset_i), .dma_en_i(dma_en_i), .mastermode_i(mastermode_i),
    .count_i(count_i), .access_in_i(access_in_i), .wait_in_i(wait_in_i),
    .master_active_o(master_active_o), .update_o(update_o), .update2d_o(update2d_o),
    .dma_busy_o(dma_busy_o), .dma_state_o(dma_state_o), .irq_done_o(irq_done_o), .irq_err_o(irq_err_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Cycle c=0 raises dma_en; START is c=1; first possible beat is c=2. A cycle is a transfer
  // cycle if it is c=2, or beats remain and wait_in was low the cycle before.
  task automatic run_xfer(input string tag, input int in0, input int out0, input bit mm,
                          input int pw, input int wst, input int wlen, input bit alt);
    int n, beats, last;
    bit wprev, w, a, xfer, stall, upd, u2d, idn, ier, fin;
    logic [2:0] st;
    inner = CW'(in0); outer = CW'(out0); reload = CW'(in0);
    n = in0 * out0; beats = 0; last = -1; wprev = 1'b0; fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk_i);
      w = (c < 2) ? 1'b0 : (wlen > 0) ? (c >= wst && c < wst + wlen) : ($urandom_range(99) < pw);
      a = alt ? (c % 2 == 0) : ($urandom_range(99) < 60);
      dma_en_i = 1'b1; wait_in_i = w; access_in_i = a;
      mastermode_i = (c <= 1) ? mm : 1'($urandom);
      xfer  = n > 0 && beats < n && (c == 2 || (c > 2 && !wprev));
      stall = n > 0 && beats < n && c > 2 && wprev;
      upd   = xfer && !w && (mm || a);
      u2d   = upd && inner == CW'(1) && outer > CW'(1);
      idn   = n > 0 && last >= 0 && c == last + 1;
      ier   = n == 0 && c == 2;
      st    = c == 0 ? 3'd0 : c == 1 ? 3'd1 : ier ? 3'd5 : xfer ? 3'd2 : stall ? 3'd3 : idn ? 3'd4 : 3'd0;
      #1 chk($sformatf("%s_c%0d", tag, c), 32'(obs), 32'({st, st != 3'd0, mm && xfer, upd, u2d, idn, ier}));
      @(posedge clk_i);
      #1;
      if (upd) begin
        beats++;
        if (beats == n) last = c;
        if (u2d) begin outer = outer - 1'b1; inner = reload; end
        else inner = inner - 1'b1;
      end
      wprev = w;
      fin = (n == 0) ? (c >= 5) : (last >= 0 && c >= last + 4);
    end
    chk({tag, "_finished"}, 32'(fin), 32'd1);
    if (n > 0) chk({tag, "_count"}, count_i, {16'd1, 16'd0});
    dma_en_i = 1'b0; wait_in_i = 1'b0; access_in_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
  endtask
  initial begin
    nreset_i = 1'b0; dma_en_i = 1'b0; mastermode_i = 1'b0; access_in_i = 1'b0; wait_in_i = 1'b0;
    inner = '0; outer = '0; reload = '0;
    #12 chk("reset", 32'(obs), 32'd0);
    @(negedge clk_i) nreset_i = 1'b1;
    @(negedge clk_i);
    run_xfer("m1d", 4, 1, 1'b1, 0, 0, 0, 1'b0);
    run_xfer("m2d", 2, 2, 1'b1, 0, 0, 0, 1'b0);
    run_xfer("stall", 4, 1, 1'b1, 0, 4, 3, 1'b0);
    run_xfer("lastwait", 2, 1, 1'b1, 0, 3, 2, 1'b0);
    run_xfer("slave", 3, 1, 1'b0, 0, 0, 0, 1'b1);
    run_xfer("err_in", 0, 1, 1'b1, 0, 0, 0, 1'b0);
    run_xfer("err_out", 3, 0, 1'b1, 0, 0, 0, 1'b0);
    // abort after two beats: dma_en drops in a stalled cycle, count keeps its partial value
    inner = 16'd4; outer = 16'd1; reload = 16'd4; mastermode_i = 1'b1;
    @(negedge clk_i) dma_en_i = 1'b1;
    @(negedge clk_i);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk_i);
      #1 chk($sformatf("abort_beat%0d", b), 32'(update_o), 32'd1);
      @(posedge clk_i);
      #1 inner = inner - 1'b1;
    end
    @(negedge clk_i) begin dma_en_i = 1'b0; wait_in_i = 1'b1; end
    #1 chk("abort_drop", 32'(obs), 32'({3'd2, 1'b1, 1'b1, 4'b0}));
    @(negedge clk_i) wait_in_i = 1'b0;
    #1 chk("abort_idle", 32'(obs), 32'd0);
    chk("abort_cnt", count_i, 32'h0001_0002);
    @(negedge clk_i);
    // asynchronous reset in the middle of a transfer
    inner = 16'd4; outer = 16'd1; reload = 16'd4;
    @(negedge clk_i) dma_en_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    #1 chk("rst_pre", 32'(update_o), 32'd1);
    #1 nreset_i = 1'b0;
    #1 chk("rst_mid", 32'(obs), 32'd0);
    dma_en_i = 1'b0;
    @(negedge clk_i) nreset_i = 1'b1;
    @(negedge clk_i);
    for (int i = 0; i < 20; i++)
      run_xfer($sformatf("rnd%0d", i), int'($urandom_range(1, 5)), int'($urandom_range(1, 4)),
               1'($urandom), int'($urandom_range(0, 50)), 0, 0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
